// File: rtl/glm_sched_pkg.sv
// rtl/glm_sched_pkg.sv - shared types and constants for the GLM modify sequencer
package glm_sched_pkg;

    localparam int NUM_REGS      = 8;
    localparam int IDX_WIDTH_DEF = 20;

    localparam int REG_BASE_IDX = 0;
    localparam int REG_COUNT    = 1;
    localparam int REG_EPOCHS   = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } t_schedstate;

    // Replace the base-index word of a register set with a per-sample index.
    function automatic logic [32*NUM_REGS-1:0] f_set_index(
        input logic [32*NUM_REGS-1:0] r,
        input logic [31:0]            idx
    );
        logic [32*NUM_REGS-1:0] v;
        v = r;
        v[32*REG_BASE_IDX +: 32] = idx;
        return v;
    endfunction

endpackage

// File: rtl/glm_sched_counter.sv
// rtl/glm_sched_counter.sv - sample/epoch/index nesting for the GLM modify sequencer
module glm_sched_counter #(
    parameter int IDX_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic [IDX_WIDTH-1:0] i_base,
    input  logic [31:0]          i_cnt,
    input  logic [31:0]          i_ep,
    input  logic                 i_advance,
    output logic [IDX_WIDTH-1:0] o_idx_next,
    output logic                 o_last_sample,
    output logic                 o_last_epoch
);

    logic [IDX_WIDTH-1:0] r_base;
    logic [IDX_WIDTH-1:0] r_idx;
    logic [31:0]          r_cnt;
    logic [31:0]          r_ep;
    logic [31:0]          r_sample_cnt;
    logic [31:0]          r_epoch_cnt;

    assign o_last_sample = ((r_sample_cnt + 32'd1) == r_cnt);
    assign o_last_epoch  = ((r_epoch_cnt + 32'd1) == r_ep);
    // Index of the sample issued after the current one; the add wraps modulo 2^IDX_WIDTH.
    assign o_idx_next    = o_last_sample ? r_base : (r_idx + IDX_WIDTH'(1));

    // Load a fresh command, or step to the next sample (rolling into the next epoch).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base       <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_ep         <= '0;
            r_sample_cnt <= '0;
            r_epoch_cnt  <= '0;
        end else if (i_load) begin
            r_base       <= i_base;
            r_idx        <= i_base;
            r_cnt        <= i_cnt;
            r_ep         <= i_ep;
            r_sample_cnt <= '0;
            r_epoch_cnt  <= '0;
        end else if (i_advance) begin
            r_idx <= o_idx_next;
            if (o_last_sample) begin
                r_sample_cnt <= '0;
                r_epoch_cnt  <= r_epoch_cnt + 32'd1;
            end else begin
                r_sample_cnt <= r_sample_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/glm_modify_sched.sv
// rtl/glm_modify_sched.sv - per-sample command sequencer for the GLM modify stage (optional GLM_MODIFY_SCHED_WATCHDOG_EN)
module glm_modify_sched
    import glm_sched_pkg::*;
#(
    parameter int IDX_WIDTH = IDX_WIDTH_DEF
`ifdef GLM_MODIFY_SCHED_WATCHDOG_EN
    ,
    parameter int WATCHDOG_CYCLES = 4096
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   op_start,
    output logic                   op_done,
    input  logic [32*NUM_REGS-1:0] regs,
    output logic                   child_op_start,
    input  logic                   child_op_done,
    output logic [32*NUM_REGS-1:0] child_regs,
    output logic                   busy,
    output logic [31:0]            samples_done,
    output logic                   error
);

    t_schedstate            r_state;
    t_schedstate            w_next_state;
    logic [32*NUM_REGS-1:0] r_shadow;

    logic                   w_accept;
    logic                   w_advance;
    logic                   w_complete;
    logic                   w_timeout;
    logic                   w_empty;
    logic                   w_last_sample;
    logic                   w_last_epoch;
    logic [IDX_WIDTH-1:0]   w_base;
    logic [IDX_WIDTH-1:0]   w_idx_next;
    logic [31:0]            w_idx_ext;

    assign w_base  = regs[32*REG_BASE_IDX +: IDX_WIDTH];
    assign w_empty = (regs[32*REG_COUNT +: 32] == 32'd0) || (regs[32*REG_EPOCHS +: 32] == 32'd0);
    // Index for the sample about to be issued: the base on accept, else the counter's successor.
    assign w_idx_ext = 32'(w_accept ? w_base : w_idx_next);

    glm_sched_counter #(
        .IDX_WIDTH(IDX_WIDTH)
    ) u_counter (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_accept),
        .i_base        (w_base),
        .i_cnt         (regs[32*REG_COUNT +: 32]),
        .i_ep          (regs[32*REG_EPOCHS +: 32]),
        .i_advance     (w_advance),
        .o_idx_next    (w_idx_next),
        .o_last_sample (w_last_sample),
        .o_last_epoch  (w_last_epoch)
    );

`ifdef GLM_MODIFY_SCHED_WATCHDOG_EN
    logic [31:0] r_wd;
    logic        r_error;

    assign w_timeout = (r_state == S_WAIT) && !child_op_done &&
                       (r_wd == 32'(WATCHDOG_CYCLES - 1));
    assign error     = r_error;

    // Count cycles spent waiting on the modify stage; restarts on every WAIT entry.
    always_ff @(posedge clk) begin
        if (reset || (r_state != S_WAIT)) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 32'd1;
        end
    end

    // Sticky timeout flag, cleared by the next accepted command.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (op_start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_empty ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (child_op_done) begin
                    w_complete = 1'b1;
                    if (w_last_sample && w_last_epoch) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_next_state = S_ISSUE;
                    end
                end else if (w_timeout) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Registered outputs; child_regs are loaded on the edge into ISSUE so they settle a cycle before the start pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_done        <= 1'b0;
            child_op_start <= 1'b0;
            child_regs     <= '0;
            busy           <= 1'b0;
            samples_done   <= '0;
            r_shadow       <= '0;
        end else begin
            op_done        <= (r_state == S_DONE);
            child_op_start <= (r_state == S_ISSUE);
            if (w_accept) begin
                busy         <= 1'b1;
                samples_done <= '0;
                r_shadow     <= regs;
            end else if (r_state == S_DONE) begin
                busy <= 1'b0;
            end
            if (w_accept && !w_empty) begin
                child_regs <= f_set_index(regs, w_idx_ext);
            end else if (w_advance) begin
                child_regs <= f_set_index(r_shadow, w_idx_ext);
            end
            if (w_complete) begin
                samples_done <= samples_done + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_glm_modify_sched.sv
// tb/tb_glm_modify_sched.sv - directed self-checking bench for glm_modify_sched
module tb_glm_modify_sched;
    import glm_sched_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   op_start;
    logic                   op_done;
    logic [32*NUM_REGS-1:0] regs;
    logic                   child_op_start;
    logic                   child_op_done;
    logic [32*NUM_REGS-1:0] child_regs;
    logic                   busy;
    logic [31:0]            samples_done;
    logic                   error;
    logic                   resp_done = 1'b0;
    logic                   spur_done = 1'b0;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          resp_lat = 5;
    int          resp_cd = 0;
    bit          resp_en = 1'b1;
    int          busy_cycles = 0;
    logic [31:0] q_idx[$];
    logic [31:0] q_r2[$];
    int          q_st[$];
    int          q_cd[$];
    int          q_done[$];

    assign child_op_done = resp_done | spur_done;

    always #5 clk = ~clk;

`ifdef GLM_MODIFY_SCHED_WATCHDOG_EN
    glm_modify_sched #(.IDX_WIDTH(20), .WATCHDOG_CYCLES(16)) dut (
`else
    glm_modify_sched #(.IDX_WIDTH(20)) dut (
`endif
        .clk            (clk),
        .reset          (reset),
        .op_start       (op_start),
        .op_done        (op_done),
        .regs           (regs),
        .child_op_start (child_op_start),
        .child_op_done  (child_op_done),
        .child_regs     (child_regs),
        .busy           (busy),
        .samples_done   (samples_done),
        .error          (error)
    );

    always @(posedge clk) cyc = cyc + 1;

    // Event log at negedge plus a modify-stage model replying resp_lat cycles after each start.
    always begin
        @(negedge clk);
        if (child_op_start === 1'b1) begin
            q_idx.push_back(child_regs[31:0]);
            q_r2.push_back(child_regs[95:64]);
            q_st.push_back(cyc);
            if (resp_en) resp_cd = resp_lat;
        end
        if (child_op_done === 1'b1) q_cd.push_back(cyc);
        if (op_done === 1'b1) q_done.push_back(cyc);
        if (busy === 1'b1) busy_cycles++;
        @(posedge clk);
        #1;
        resp_done = 1'b0;
        if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) resp_done = 1'b1;
        end
    end

    task automatic clear_log();
        q_idx.delete(); q_r2.delete(); q_st.delete(); q_cd.delete(); q_done.delete();
        busy_cycles = 0;
    endtask

    task automatic start_cmd(input logic [31:0] base, input logic [31:0] cnt,
                             input logic [31:0] ep, output int t0);
        @(posedge clk); #1;
        regs = '0;
        regs[31:0]    = base;
        regs[63:32]   = cnt;
        regs[95:64]   = 32'hDEAD0002;
        regs[255:224] = ep;
        op_start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        op_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (q_done.size() == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (q_done.size() == 0) begin
            miscompares++;
            $display("FAIL op_done_timeout: no op_done within %0d cycles", budget);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; op_start = 1'b0; regs = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({op_done, child_op_start, busy, error} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {op_done, child_op_start, busy, error});
        end
        vectors++;
        if (child_regs !== '0 || samples_done !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_regs: child_regs0=%h samples_done=%0d want 0", child_regs[31:0], samples_done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        regs = '0;
    endtask

    task automatic test_single_epoch();
        int t0;
        clear_log(); resp_en = 1'b1; resp_lat = 5;
        start_cmd(32'd32, 32'd3, 32'd1, t0);
        wait_done(200);
        vectors++;
        if (q_st.size() != 3) begin
            miscompares++; $display("FAIL s1_starts: got %0d want 3", q_st.size());
        end
        for (int i = 0; i < 3 && i < q_idx.size(); i++) begin
            vectors++;
            if (q_idx[i] !== 32'(32 + i)) begin
                miscompares++; $display("FAIL s1_idx%0d: got %0d want %0d", i, q_idx[i], 32 + i);
            end
        end
        vectors++;
        if (q_st.size() < 1 || q_st[0] != t0 + 2) begin
            miscompares++; $display("FAIL s1_first_start: got %0d want %0d", q_st.size() ? q_st[0] : -1, t0 + 2);
        end
        for (int i = 1; i < 3 && i < q_st.size() && i <= q_cd.size(); i++) begin
            vectors++;
            if (q_st[i] - q_cd[i-1] != 2) begin
                miscompares++; $display("FAIL s1_gap%0d: got %0d want 2", i, q_st[i] - q_cd[i-1]);
            end
        end
        vectors++;
        if (q_done.size() != 1 || q_cd.size() != 3 || q_done[0] != q_cd[2] + 2) begin
            miscompares++; $display("FAIL s1_op_done: pulses=%0d completions=%0d want 1 pulse 2 cycles after 3rd completion", q_done.size(), q_cd.size());
        end
        vectors++;
        if (samples_done !== 32'd3 || busy !== 1'b0) begin
            miscompares++; $display("FAIL s1_final: samples_done=%0d busy=%b want 3 0", samples_done, busy);
        end
        vectors++;
        if (q_r2.size() < 1 || q_r2[0] !== 32'hDEAD0002) begin
            miscompares++; $display("FAIL s1_forward: got %h want DEAD0002", q_r2.size() ? q_r2[0] : 32'h0);
        end
    endtask

    task automatic test_multi_epoch();
        int          t0;
        logic [31:0] exp_idx[6] = '{0, 1, 0, 1, 0, 1};
        clear_log(); resp_en = 1'b1; resp_lat = 3;
        start_cmd(32'd0, 32'd2, 32'd3, t0);
        wait_done(300);
        vectors++;
        if (q_idx.size() != 6) begin
            miscompares++; $display("FAIL s2_starts: got %0d want 6", q_idx.size());
        end
        for (int i = 0; i < 6 && i < q_idx.size(); i++) begin
            vectors++;
            if (q_idx[i] !== exp_idx[i]) begin
                miscompares++; $display("FAIL s2_idx%0d: got %0d want %0d", i, q_idx[i], exp_idx[i]);
            end
        end
        vectors++;
        if (q_done.size() != 1 || q_cd.size() != 6 || q_done[0] != q_cd[5] + 2 || samples_done !== 32'd6) begin
            miscompares++; $display("FAIL s2_done: pulses=%0d samples_done=%0d want 1 6", q_done.size(), samples_done);
        end
    endtask

    task automatic test_empty(input logic [31:0] cnt, input logic [31:0] ep);
        int t0;
        clear_log(); resp_en = 1'b1;
        start_cmd(32'd9, cnt, ep, t0);
        wait_done(20);
        vectors++;
        if (q_st.size() != 0 || q_done.size() != 1 || q_done[0] != t0 + 2) begin
            miscompares++; $display("FAIL empty_c%0d_e%0d: starts=%0d done_at=%0d want 0 %0d", cnt, ep, q_st.size(), q_done.size() ? q_done[0] - t0 : -1, 2);
        end
        vectors++;
        if (busy_cycles != 1 || samples_done !== 32'd0) begin
            miscompares++; $display("FAIL empty_busy: busy_cycles=%0d samples_done=%0d want 1 0", busy_cycles, samples_done);
        end
    endtask

    task automatic test_wrap();
        int t0;
        clear_log(); resp_en = 1'b1; resp_lat = 2;
        start_cmd(32'hABCF_FFFF, 32'd2, 32'd1, t0);
        wait_done(100);
        vectors++;
        if (q_idx.size() != 2 || q_idx[0] !== 32'h000F_FFFF || q_idx[1] !== 32'h0000_0000) begin
            miscompares++; $display("FAIL wrap_idx: n=%0d first=%h second=%h want 000fffff 00000000", q_idx.size(), q_idx.size() > 0 ? q_idx[0] : 32'h0, q_idx.size() > 1 ? q_idx[1] : 32'h0);
        end
    endtask

    task automatic test_ignored();
        int t0;
        clear_log(); resp_en = 1'b1; resp_lat = 5;
        @(posedge clk); #1; spur_done = 1'b1;
        @(posedge clk); #1; spur_done = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (q_st.size() != 0 || q_done.size() != 0 || busy_cycles != 0 || samples_done !== 32'd2) begin
            miscompares++; $display("FAIL spurious_done: starts=%0d dones=%0d busy=%0d samples=%0d want 0 0 0 2", q_st.size(), q_done.size(), busy_cycles, samples_done);
        end
        clear_log();
        start_cmd(32'd32, 32'd3, 32'd1, t0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        regs[31:0] = 32'd100; regs[63:32] = 32'd9; regs[95:64] = 32'h1234_5678;
        op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        wait_done(200);
        vectors++;
        if (q_idx.size() != 3 || q_idx[0] !== 32'd32 || q_idx[1] !== 32'd33 || q_idx[2] !== 32'd34) begin
            miscompares++; $display("FAIL busy_start_idx: n=%0d want 32,33,34", q_idx.size());
        end
        vectors++;
        if (q_r2.size() != 3 || q_r2[2] !== 32'hDEAD0002 || q_done.size() != 1 || samples_done !== 32'd3) begin
            miscompares++; $display("FAIL busy_start_misc: dones=%0d samples=%0d want 1 3", q_done.size(), samples_done);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        clear_log(); resp_en = 1'b0;
        start_cmd(32'd7, 32'd5, 32'd1, t0);
        repeat (4) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || q_st.size() != 1) begin
            miscompares++; $display("FAIL mid_wait: busy=%b starts=%0d want 1 1", busy, q_st.size());
        end
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({op_done, child_op_start, busy, error} !== 4'b0000 || child_regs !== '0 || samples_done !== 32'd0) begin
            miscompares++; $display("FAIL mid_reset: flags=%b child_regs0=%h samples=%0d want zeros", {op_done, child_op_start, busy, error}, child_regs[31:0], samples_done);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (q_done.size() != 0 || q_st.size() != 1) begin
            miscompares++; $display("FAIL mid_no_done: dones=%0d starts=%0d want 0 1", q_done.size(), q_st.size());
        end
        clear_log(); resp_en = 1'b1; resp_lat = 1;
        start_cmd(32'd4, 32'd1, 32'd1, t0);
        wait_done(50);
        vectors++;
        if (q_idx.size() != 1 || q_idx[0] !== 32'd4 || samples_done !== 32'd1) begin
            miscompares++; $display("FAIL post_reset_cmd: n=%0d samples=%0d want 1 1", q_idx.size(), samples_done);
        end
    endtask

`ifdef GLM_MODIFY_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int t0;
        int d;
        clear_log(); resp_en = 1'b0;
        start_cmd(32'd5, 32'd1, 32'd1, t0);
        wait_done(100);
        d = (q_done.size() > 0 && q_st.size() > 0) ? q_done[0] - q_st[0] : -1;
        vectors++;
        if (error !== 1'b1 || (d != 16 && d != 17)) begin
            miscompares++; $display("FAIL watchdog: error=%b done_after_wait=%0d want 1 16..17", error, d);
        end
        clear_log(); resp_en = 1'b1; resp_lat = 2;
        start_cmd(32'd5, 32'd1, 32'd1, t0);
        @(negedge clk);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++; $display("FAIL watchdog_clear: error=%b want 0", error);
        end
        wait_done(50);
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_single_epoch();
        test_multi_epoch();
        test_empty(32'd0, 32'd1);
        test_empty(32'd4, 32'd0);
        test_wrap();
        test_ignored();
        test_reset_mid();
`ifdef GLM_MODIFY_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
